wash_cycle_sequencer: RTL
=========================

WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 SHALL have parameter FILL_T, default 8'd10, fill phase length in ticks.
REQ-002 SHALL have parameter WASH_T, default 8'd40, wash phase length in ticks.
REQ-003 SHALL have parameter RINSE_T, default 8'd20, rinse phase length in ticks.
REQ-004 SHALL have parameter SPIN_T, default 8'd15, spin phase length in ticks.
REQ-005 SHALL have parameter DRAIN_T, default 8'd5, abort-drain phase length in ticks.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: cycle request, sampled each clk.
REQ-009 SHALL have port abort, input, 1 bit: abort request, sampled each clk.
REQ-010 SHALL have port door_closed, input, 1 bit: 1 = door latched.
REQ-011 SHALL have port tick, input, 1 bit: one-cycle time-base pulse.
REQ-012 SHALL have port dp_ctrl, output, 3 bits: registered op code to the shared 8-bit op unit (000 = clear, 001 = minus 1).
REQ-013 SHALL have port dp_data, output, 8 bits: registered operand to the op unit.
REQ-014 SHALL have port dp_result, input, 8 bits: registered op-unit result, valid one clk after dp_ctrl/dp_data are presented.
REQ-015 SHALL have port phase, output, 3 bits: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5, DRAIN=6.
REQ-016 SHALL have ports valve_on, motor_on and drain_on, outputs, 1 bit each: actuator enables.
REQ-017 SHALL have ports busy and done, outputs, 1 bit each: busy = phase not IDLE/DONE; done = one-cycle completion pulse.
REQ-018 SHALL have port tick_overrun, output, 1 bit: sticky flag, tick arrived while a decrement was pending.

Function
REQ-019 SHALL hold an 8-bit remaining count rem, loaded with the phase parameter on every phase entry.
REQ-020 SHALL, on a tick with rem!=0, no pending decrement and not paused, drive dp_ctrl=001 and dp_data=rem in the next cycle, and set pending.
REQ-021 SHALL capture dp_result into rem two cycles after that issue and clear pending; rem SHALL never be computed locally.
REQ-022 SHALL drive dp_ctrl=000 and dp_data=0 in every cycle that issues no decrement.
REQ-023 SHALL drop a tick arriving while pending and set tick_overrun; the flag clears only on reset or an accepted start.
REQ-024 SHALL, when rem==0 and not pending, advance the phase: FILL->WASH->RINSE->SPIN->DONE, reloading rem; a zero-length phase lasts exactly one cycle.
REQ-025 SHALL accept start only in IDLE with door_closed=1: enter FILL and load FILL_T; otherwise ignore start.
REQ-026 SHALL, on abort in FILL..SPIN, enter DRAIN with rem=DRAIN_T; any pending result is discarded. DRAIN SHALL end in IDLE with no done pulse. abort in IDLE/DONE/DRAIN SHALL be ignored.
REQ-027 SHALL, on abort and tick in the same cycle, give abort priority; the tick is discarded.
REQ-028 SHALL pause while door_closed=0 in FILL..SPIN: no new issue, rem held, valve_on/motor_on forced 0. A pending result SHALL still be captured. Resume on door_closed=1.
REQ-029 SHALL, in DONE, assert done for exactly that one cycle and then return to IDLE.
REQ-030 SHALL decode actuators from phase: valve_on=FILL; motor_on=WASH|RINSE|SPIN; drain_on=SPIN|DRAIN, with drain_on unaffected by pause.

Reset
REQ-031 SHALL, while rst=1, set phase=IDLE, rem=0, pending=0, dp_ctrl=000, dp_data=0, all actuators, busy, done and tick_overrun=0, regardless of clk.
REQ-032 SHALL, on reset asserted mid-cycle, abandon any pending result and restart only on a new start.

Verification (FILL_T=2, WASH_T=3, RINSE_T=1, SPIN_T=2, DRAIN_T=1; op-unit model: result = data-1 when ctrl=001, else 0)
REQ-033 SHALL cover the full cycle: start with door closed, then a tick every 4 clk -> phases 1,2,3,4,5 after 2,3,1,2 ticks; done high for 1 clk; phase=0; tick_overrun=0.
REQ-034 SHALL cover issue timing: a tick in FILL -> next clk dp_ctrl=001 and dp_data=2; the clk after that dp_ctrl=000; rem=1 one clk later.
REQ-035 SHALL cover overrun: two ticks 1 clk apart in WASH -> rem decrements once; tick_overrun=1 and stays 1 until the next start.
REQ-036 SHALL cover abort: abort in WASH with rem=2 and a same-cycle tick -> phase=6, drain_on=1, motor_on=0; after 1 accepted tick, phase=0 and done never pulses.
REQ-037 SHALL cover pause: door_closed=0 in RINSE for 10 clk carrying 2 ticks -> rem unchanged and motor_on=0; after door_closed=1, resumes and reaches SPIN after 1 more tick.
REQ-038 SHALL cover reset and door: rst during SPIN with a decrement pending -> all outputs 0 immediately; start with door_closed=0 -> phase stays 0.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// Wash-cycle sequencer.
// Steps a wash through FILL -> WASH -> RINSE -> SPIN -> DONE. Each phase holds
// an 8-bit remaining-tick count. The count is never decremented here: every
// accepted tick sends a "minus 1" op to a shared, registered 8-bit op unit, and
// the result is written back two cycles after the op is presented. An abort
// sends the machine to DRAIN, which returns to IDLE without a done pulse.
// An open door pauses the run phases.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      cycle request / abort request
//   door_closed       1 = door latched; 0 pauses FILL..SPIN
//   tick              one-cycle time-base pulse
//   dp_ctrl, dp_data  registered op code / operand to the op unit (000 = clear, 001 = minus 1)
//   dp_result         op-unit result, valid one clk after dp_ctrl/dp_data
//   phase             IDLE=0 FILL=1 WASH=2 RINSE=3 SPIN=4 DONE=5 DRAIN=6
//   valve_on, motor_on, drain_on   actuator enables
//   busy, done        phase not IDLE/DONE; one-cycle completion pulse
//   tick_overrun      sticky: a tick arrived while a decrement was in flight
module wash_cycle_sequencer #(
  parameter logic [7:0] FILL_T  = 8'd10,
  parameter logic [7:0] WASH_T  = 8'd40,
  parameter logic [7:0] RINSE_T = 8'd20,
  parameter logic [7:0] SPIN_T  = 8'd15,
  parameter logic [7:0] DRAIN_T = 8'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic       tick,
  output logic [2:0] dp_ctrl,
  output logic [7:0] dp_data,
  input  logic [7:0] dp_result,
  output logic [2:0] phase,
  output logic       valve_on,
  output logic       motor_on,
  output logic       drain_on,
  output logic       busy,
  output logic       done,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DONE  = 3'd5,
    DRAIN = 3'd6
  } phase_e;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_DEC = 3'b001;

  phase_e     phase_q, phase_d;
  logic [7:0] rem_q, rem_d;
  // [0]: op presented this cycle, [1]: its result is on dp_result this cycle
  logic [1:0] pend_q, pend_d;
  logic [2:0] dp_ctrl_q, dp_ctrl_d;
  logic [7:0] dp_data_q, dp_data_d;
  logic       ovr_q, ovr_d;

  logic in_run, paused, pend;

  assign in_run = (phase_q == FILL) || (phase_q == WASH) ||
                  (phase_q == RINSE) || (phase_q == SPIN);
  assign paused = in_run && !door_closed;
  assign pend   = |pend_q;

  always_comb begin
    phase_d   = phase_q;
    rem_d     = rem_q;
    pend_d    = {pend_q[0], 1'b0};
    dp_ctrl_d = OP_CLR;
    dp_data_d = 8'd0;
    ovr_d     = ovr_q;
    case (phase_q)
      IDLE: begin
        if (start && door_closed) begin
          phase_d = FILL;
          rem_d   = FILL_T;
          ovr_d   = 1'b0;
        end
      end
      DONE: begin
        phase_d = IDLE;
        rem_d   = 8'd0;
      end
      default: begin
        // Abort wins over everything else this cycle, including a tick and
        // any decrement still in flight (its result is thrown away).
        if (abort && in_run) begin
          phase_d = DRAIN;
          rem_d   = DRAIN_T;
          pend_d  = 2'b00;
        end else begin
          if (tick && pend) ovr_d = 1'b1;
          if (pend_q[1]) begin
            // write-back is allowed even while paused
            rem_d = dp_result;
          end else if (!pend && !paused && rem_q == 8'd0) begin
            case (phase_q)
              FILL:    begin phase_d = WASH;  rem_d = WASH_T;  end
              WASH:    begin phase_d = RINSE; rem_d = RINSE_T; end
              RINSE:   begin phase_d = SPIN;  rem_d = SPIN_T;  end
              SPIN:    begin phase_d = DONE;  rem_d = 8'd0;    end
              default: begin phase_d = IDLE;  rem_d = 8'd0;    end
            endcase
          end else if (!pend && !paused && tick) begin
            dp_ctrl_d = OP_DEC;
            dp_data_d = rem_q;
            pend_d    = 2'b01;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= IDLE;
      rem_q     <= 8'd0;
      pend_q    <= 2'b00;
      dp_ctrl_q <= OP_CLR;
      dp_data_q <= 8'd0;
      ovr_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      pend_q    <= pend_d;
      dp_ctrl_q <= dp_ctrl_d;
      dp_data_q <= dp_data_d;
      ovr_q     <= ovr_d;
    end
  end

  assign dp_ctrl      = dp_ctrl_q;
  assign dp_data      = dp_data_q;
  assign phase        = phase_q;
  assign tick_overrun = ovr_q;
  assign busy         = in_run || (phase_q == DRAIN);
  assign done         = (phase_q == DONE);
  // Pause gates valve/motor only; draining keeps going with the door open.
  assign valve_on     = (phase_q == FILL) && door_closed;
  assign motor_on     = ((phase_q == WASH) || (phase_q == RINSE) ||
                         (phase_q == SPIN)) && door_closed;
  assign drain_on     = (phase_q == SPIN) || (phase_q == DRAIN);

endmodule
